// File: rtl/mop_issue_scheduler.sv
// In-order issue stage: micro-op FIFO plus a register scoreboard that holds the head until its registers are free.
// Define MUSK_SB_WB_BYPASS_EN so that a writeback in the current cycle can also unblock the head in that cycle.
module mop_issue_scheduler #(
   parameter int REG_FILE_SIZE = 16,
   parameter int REG_ID_W      = 5,
   parameter int PAYLOAD_W     = 128,
   parameter int DEPTH         = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [REG_ID_W-1:0]      in_src0_id,
   input  logic [REG_ID_W-1:0]      in_src1_id,
   input  logic [REG_ID_W-1:0]      in_dst_id,
   input  logic [PAYLOAD_W-1:0]     in_payload,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [REG_ID_W-1:0]      out_src0_id,
   output logic [REG_ID_W-1:0]      out_src1_id,
   output logic [REG_ID_W-1:0]      out_dst_id,
   output logic [PAYLOAD_W-1:0]     out_payload,
   input  logic                     wb_valid,
   input  logic [REG_ID_W-1:0]      wb_dst_id,
   output logic [REG_FILE_SIZE-1:0] sb_state,
   output logic [15:0]              stall_cnt
);

   localparam int AW    = $clog2(DEPTH);
   localparam int IDX_W = $clog2(REG_FILE_SIZE);
   localparam logic [REG_ID_W:0] TRACK_LIM = (REG_ID_W+1)'(REG_FILE_SIZE);

   // Ids 0..REG_FILE_SIZE-1 are the tracked architectural registers; ids above that
   // (rip=16, rimm=17, rv0=18, rv8=19, rnil=31) are pseudo-registers with no bit.
   function automatic logic [REG_FILE_SIZE-1:0] reg_mask(input logic [REG_ID_W-1:0] id);
      logic [REG_FILE_SIZE-1:0] m;
      m = '0;
      if ({1'b0, id} < TRACK_LIM)
         m[id[IDX_W-1:0]] = 1'b1;
      return m;
   endfunction

   logic [REG_ID_W-1:0]      src0_mem [DEPTH];
   logic [REG_ID_W-1:0]      src1_mem [DEPTH];
   logic [REG_ID_W-1:0]      dst_mem  [DEPTH];
   logic [PAYLOAD_W-1:0]     pay_mem  [DEPTH];

   logic [AW:0]              wr_ptr;
   logic [AW:0]              rd_ptr;
   logic                     empty;
   logic                     full;
   logic                     enq;
   logic                     deq;
   logic [REG_FILE_SIZE-1:0] wb_mask;
   logic [REG_FILE_SIZE-1:0] need_mask;
   logic [REG_FILE_SIZE-1:0] set_mask;
   logic [REG_FILE_SIZE-1:0] sb_eff;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign in_ready = !full;

   assign out_src0_id = src0_mem[rd_ptr[AW-1:0]];
   assign out_src1_id = src1_mem[rd_ptr[AW-1:0]];
   assign out_dst_id  = dst_mem[rd_ptr[AW-1:0]];
   assign out_payload = pay_mem[rd_ptr[AW-1:0]];

   assign wb_mask   = wb_valid ? reg_mask(wb_dst_id) : '0;
   assign need_mask = reg_mask(out_src0_id) | reg_mask(out_src1_id) | reg_mask(out_dst_id);

`ifdef MUSK_SB_WB_BYPASS_EN
   assign sb_eff = sb_state & ~wb_mask;
`else
   assign sb_eff = sb_state;
`endif

   assign out_valid = !empty && ((need_mask & sb_eff) == '0);
   assign enq       = in_valid && in_ready && !flush;
   assign deq       = out_valid && out_ready && !flush;
   assign set_mask  = deq ? reg_mask(out_dst_id) : '0;

   always_ff @(posedge clk) begin
      if (enq) begin
         src0_mem[wr_ptr[AW-1:0]] <= in_src0_id;
         src1_mem[wr_ptr[AW-1:0]] <= in_src1_id;
         dst_mem[wr_ptr[AW-1:0]]  <= in_dst_id;
         pay_mem[wr_ptr[AW-1:0]]  <= in_payload;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         sb_state  <= '0;
         stall_cnt <= '0;
      end else begin
         if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sb_state <= '0;
         end else begin
            if (enq)
               wr_ptr <= wr_ptr + (AW+1)'(1);
            if (deq)
               rd_ptr <= rd_ptr + (AW+1)'(1);
            // The set is OR-ed after the clear so a new writer stays pending.
            sb_state <= (sb_state & ~wb_mask) | set_mask;
         end
         // Stall history is diagnostic and survives flush.
         if (!empty && !out_valid && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_mop_issue_scheduler.sv
// Scoreboard bench for mop_issue_scheduler: stimulus queues expected issues, a monitor pops and compares.
module tb_mop_issue_scheduler;

   localparam logic [4:0] R1 = 5'd1, R2 = 5'd2, R3 = 5'd3, R4 = 5'd4, R5 = 5'd5;
   localparam logic [4:0] R6 = 5'd6, R7 = 5'd7, R8 = 5'd8;
   localparam logic [4:0] RIP = 5'd16, RIMM = 5'd17, RV0 = 5'd18, RV8 = 5'd19, RNIL = 5'd31;
`ifdef MUSK_SB_WB_BYPASS_EN
   localparam int BYP = 1;
`else
   localparam int BYP = 0;
`endif

   typedef struct {
      logic [4:0]   s0;
      logic [4:0]   s1;
      logic [4:0]   d;
      logic [127:0] p;
   } op_t;

   logic         clk = 1'b0;
   logic         reset_n, flush, in_valid, in_ready, out_valid, out_ready, wb_valid;
   logic [4:0]   in_src0_id, in_src1_id, in_dst_id, wb_dst_id;
   logic [4:0]   out_src0_id, out_src1_id, out_dst_id;
   logic [127:0] in_payload, out_payload, prev_payload;
   logic [15:0]  sb_state, stall_cnt, s0_stall;
   logic         have_prev, prev_flush;

   op_t exp_q[$];
   op_t mon_e;
   int  n_checks = 0;
   int  n_errors = 0;

   mop_issue_scheduler dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_src0_id(in_src0_id), .in_src1_id(in_src1_id), .in_dst_id(in_dst_id),
      .in_payload(in_payload),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_src0_id(out_src0_id), .out_src1_id(out_src1_id), .out_dst_id(out_dst_id),
      .out_payload(out_payload),
      .wb_valid(wb_valid), .wb_dst_id(wb_dst_id),
      .sb_state(sb_state), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the op is accepted.
   task automatic enq(input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] d,
                      input logic [31:0] tag);
      op_t e;
      int  t;
      e.s0 = s0; e.s1 = s1; e.d = d; e.p = {tag, ~tag, tag ^ 32'hA5A5_5A5A, tag};
      in_src0_id = s0; in_src1_id = s1; in_dst_id = d; in_payload = e.p;
      in_valid = 1'b1;
      @(negedge clk);
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_checks++; n_errors++;
         $display("FAIL enq_timeout: in_ready stuck low for tag %0h", tag);
      end else begin
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_wb(input logic [4:0] id);
      wb_valid = 1'b1; wb_dst_id = id;
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 60) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (exp_q.size() != 0) begin
         n_checks++; n_errors++;
         $display("FAIL %s: %0d ops never issued", name, exp_q.size());
      end
   endtask

   // Monitor: pop on every accepted issue, and check head stability under backpressure.
   always @(negedge clk) begin
      if (!reset_n) begin
         have_prev = 1'b0;
      end else begin
         if (have_prev && !prev_flush) begin
            n_checks++;
            if (!out_valid || out_payload !== prev_payload) begin
               n_errors++;
               $display("FAIL hold_stable: valid %0b payload %h expected valid 1 payload %h",
                        out_valid, out_payload, prev_payload);
            end
         end
         have_prev    = out_valid && !out_ready;
         prev_payload = out_payload;
         prev_flush   = flush;
         if (out_valid && out_ready && !flush) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL issue_order: unexpected issue payload %h", out_payload);
            end else begin
               mon_e = exp_q.pop_front();
               if (out_payload !== mon_e.p ||
                   {out_src0_id, out_src1_id, out_dst_id} !== {mon_e.s0, mon_e.s1, mon_e.d}) begin
                  n_errors++;
                  $display("FAIL issue_order: got payload %h ids %h expected payload %h ids %h",
                           out_payload, {out_src0_id, out_src1_id, out_dst_id},
                           mon_e.p, {mon_e.s0, mon_e.s1, mon_e.d});
               end
            end
         end
      end
   end

   initial begin
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; wb_valid = 1'b0;
      in_src0_id = '0; in_src1_id = '0; in_dst_id = '0; in_payload = '0; wb_dst_id = '0;
      have_prev = 1'b0; prev_flush = 1'b0; prev_payload = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_sb", 32'(sb_state), 0);
      chk("rst_stall", 32'(stall_cnt), 0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // RAW hazard on r3
      out_ready = 1'b1;
      enq(R1, R2, R3, 32'h0000_00A0);
      enq(R3, R4, R6, 32'h0000_00B0);
      repeat (3) @(posedge clk);
      #1;
      chk("raw_blocked", 32'(out_valid), 0);
      chk("raw_sb", 32'(sb_state), 32'h0008);
      chk("raw_stall", 32'(stall_cnt), 3);
      wb_valid = 1'b1; wb_dst_id = R3;
      @(negedge clk);
      chk("raw_wb_cycle_valid", 32'(out_valid), BYP);
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
      chk("raw_after_wb_valid", 32'(out_valid), (BYP == 1) ? 0 : 1);
      chk("raw_stall_final", 32'(stall_cnt), (BYP == 1) ? 3 : 4);
      @(posedge clk);
      #1;
      chk("raw_dst_set", 32'(sb_state), 32'h0040);
      do_wb(R6);
      chk("raw_sb_clear", 32'(sb_state), 0);

      // Fill every scoreboard bit, then an all-untracked op must pass straight through
      for (int i = 0; i < 16; i++)
         enq(RNIL, RNIL, 5'(i), 32'h0000_0100 + 32'(i));
      wait_empty("fill_drain");
      chk("sb_all_ones", 32'(sb_state), 32'hFFFF);
      enq(RIMM, RIP, RNIL, 32'h0000_0200);
      chk("untracked_valid", 32'(out_valid), 1);
      @(posedge clk);
      #1;
      chk("untracked_sb", 32'(sb_state), 32'hFFFF);
      for (int i = 0; i < 16; i++)
         do_wb(5'(i));
      chk("sb_cleared", 32'(sb_state), 0);

      // Same-cycle set and clear on r5, then writebacks with no effect
      enq(RNIL, RNIL, R5, 32'h0000_0300);
      wb_valid = 1'b1; wb_dst_id = R5;
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
      chk("set_wins", 32'(sb_state), 32'h0020);
      do_wb(RNIL);
      chk("wb_untracked", 32'(sb_state), 32'h0020);
      do_wb(R5);
      do_wb(R5);
      chk("wb_clear_bit", 32'(sb_state), 0);

      // Full FIFO, concurrent enqueue/dequeue, pointer wrap
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         enq(RV0, RV8, RNIL, 32'h0000_0400 + 32'(i));
      chk("full_in_ready", 32'(in_ready), 0);
      chk("full_out_valid", 32'(out_valid), 1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("after_deq_in_ready", 32'(in_ready), 1);
      enq(RV0, RV8, RNIL, 32'h0000_0404);
      out_ready = 1'b0;
      chk("enq_deq_in_ready", 32'(in_ready), 1);
      enq(RV0, RV8, RNIL, 32'h0000_0405);
      chk("refill_in_ready", 32'(in_ready), 0);
      out_ready = 1'b1;
      wait_empty("full_drain");
      for (int i = 0; i < 10; i++) begin
         out_ready = (i % 3 != 2);
         enq(RNIL, RIMM, RV0, 32'h0000_0500 + 32'(i));
      end
      out_ready = 1'b1;
      wait_empty("wrap_drain");

      // Flush with r1,r2 pending and two blocked ops queued
      enq(RNIL, RNIL, R1, 32'h0000_0600);
      enq(RNIL, RNIL, R2, 32'h0000_0601);
      wait_empty("flush_setup");
      chk("flush_sb_before", 32'(sb_state), 32'h0006);
      out_ready = 1'b0;
      enq(R1, RNIL, R7, 32'h0000_0602);
      enq(RNIL, R2, R8, 32'h0000_0603);
      repeat (2) @(posedge clk);
      #1;
      s0_stall = stall_cnt;
      flush = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_sb", 32'(sb_state), 0);
      chk("flush_out_valid", 32'(out_valid), 0);
      chk("flush_in_ready", 32'(in_ready), 1);
      chk("flush_stall_kept", 32'(stall_cnt), 32'(s0_stall) + 1);
      repeat (2) @(posedge clk);
      #1;
      chk("flush_stall_idle", 32'(stall_cnt), 32'(s0_stall) + 1);
      out_ready = 1'b1;
      enq(R3, R4, R5, 32'h0000_0700);
      wait_empty("post_flush");

      // Reset mid-stream
      @(posedge clk);
      #1;
      do_wb(R5);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         enq(R1, R2, R3, 32'h0000_0800 + 32'(i));
      reset_n = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 0);
      chk("mid_rst_sb", 32'(sb_state), 0);
      chk("mid_rst_in_ready", 32'(in_ready), 1);
      chk("mid_rst_stall", 32'(stall_cnt), 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      out_ready = 1'b1;
      enq(R1, R2, R3, 32'h0000_0900);
      wait_empty("post_reset");
      @(posedge clk);
      #1;
      chk("final_sb", 32'(sb_state), 32'h0008);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
